// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO with framing/overrun pulses.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rx_in,
  output logic [7:0]                    char_out,
  output logic                          char_out_valid,
  input  logic                          char_out_ready,
  output logic                          framing_error_out,
  output logic                          overrun_out,
  output logic [$clog2(FIFO_DEPTH):0]   fill_count_out
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_T = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_T  = CW'(CPB - 1);
  localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state_q, state_d;
  logic s1_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic fe_q, fe_d, ov_q, ov_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] fill_q, fill_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic sample, wr, push, pop, full;
  assign sample = cnt_q == ((state_q == START) ? HALF_T : BIT_T);
  always_ff @(posedge clk_in)
    if (rst_in) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s_q) state_d = START;
      START:   if (sample) state_d = rx_s_q ? IDLE : DATA;
      DATA:    if (sample && idx_q == 3'd7) state_d = STOP;
      STOP:    if (sample) state_d = rx_s_q ? IDLE : BRK;
      BRK:     if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d   = (state_d != state_q || sample) ? '0 : cnt_q + 1'b1;
    idx_d   = (state_q == DATA) ? idx_q + 3'(sample) : '0;
    shreg_d = (state_q == DATA && sample) ? {rx_s_q, shreg_q[7:1]} : shreg_q;
    wr      = state_q == STOP && sample && rx_s_q;
    fe_d    = state_q == STOP && sample && !rx_s_q;
    pop     = char_out_valid && char_out_ready;
    full    = fill_q == DEPTH;
    push    = wr && (!full || pop);
    ov_d    = wr && full && !pop;
    wp_d    = wp_q + AW'(push);
    rp_d    = rp_q + AW'(pop);
    fill_d  = fill_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      s1_q    <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      fill_q  <= '0;
    end else begin
      s1_q    <= rx_in;
      rx_s_q  <= s1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fill_q  <= fill_d;
    end
  always_ff @(posedge clk_in)
    if (push) mem_q[wp_q] <= shreg_q;
  assign char_out_valid    = fill_q != '0;
  assign char_out          = char_out_valid ? mem_q[rp_q] : 8'h00;
  assign framing_error_out = fe_q;
  assign overrun_out       = ov_q;
  assign fill_count_out    = fill_q;
endmodule
